// File: rtl/maj_seq_pkg.sv
// Shared types and constants for the MAJ3 chain sequencer.
package maj_seq_pkg;

    localparam int NUM_PI     = 13;
    localparam int MAX_STAGES = 8;
    localparam int SEL_W      = $clog2(NUM_PI);
    localparam int IDX_W      = $clog2(MAX_STAGES + 1);
    localparam int ADDR_W     = $clog2(MAX_STAGES);

    // Truth table of MAJ3, indexed by {a, b, c}: high when two or more inputs are high.
    localparam logic [7:0] MAJ3_LUT = 8'hE8;

    typedef struct packed {
        logic [SEL_W-1:0] sel_a;
        logic [SEL_W-1:0] sel_b;
        logic [SEL_W-1:0] sel_c;
        logic             inv_a;
        logic             inv_b;
        logic             inv_c;
        logic             use_prev;
    } stage_desc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/maj_chain_sequencer_if.sv
// Input/output valid-ready handshakes of the MAJ3 chain sequencer.
interface maj_chain_sequencer_if;
    import maj_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [NUM_PI-1:0] in_pi;
    logic              out_valid;
    logic              out_ready;
    logic              out_po;

    // Stimulus source and result consumer side.
    modport master (
        output in_valid, in_pi, out_ready,
        input  in_ready, out_valid, out_po
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_pi, out_ready,
        output in_ready, out_valid, out_po
    );

endinterface

// File: rtl/maj3_unit.sv
// Shared combinational MAJ3 with per-operand complement applied after selection.
module maj3_unit
    import maj_seq_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic inv_a,
    input  logic inv_b,
    input  logic inv_c,
    output logic y
);

    assign y = MAJ3_LUT[{a ^ inv_a, b ^ inv_b, c ^ inv_c}];

endmodule

// File: rtl/maj_chain_sequencer.sv
// Time-multiplexed MAJ3 chain evaluator: one table stage per cycle on one maj3_unit.
// Optional feature: define MAJ_SEQ_TRACE_EN to add the per-stage out_trace port.
module maj_chain_sequencer
    import maj_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_addr,
    input  stage_desc_t           cfg_data,
    input  logic [IDX_W-1:0]      cfg_len,
    maj_chain_sequencer_if.slave  bus,
    output logic                  busy,
    output logic                  err
`ifdef MAJ_SEQ_TRACE_EN
    ,
    output logic [MAX_STAGES-1:0] out_trace
`endif
);

    localparam int SEL_SPAN = 1 << SEL_W;
    localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(NUM_PI);
    localparam logic [IDX_W-1:0] LEN_MAX   = IDX_W'(MAX_STAGES);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  len_q;
    logic [NUM_PI-1:0] pi_q;
    logic              acc;
    logic              out_valid_q;
    logic              busy_q;
    logic              err_q;
    stage_desc_t       stage_tbl [MAX_STAGES];

    stage_desc_t       desc;
    logic              op_a;
    logic              op_b;
    logic              op_c;
    logic              sel_bad;
    logic              stage_res;
    logic              len_ok;
    logic              can_accept;
    logic              accept;

    // Out-of-range selects read zero: the vector is zero-extended to the full select span.
    function automatic logic pick(input logic [NUM_PI-1:0] v, input logic [SEL_W-1:0] s);
        logic [SEL_SPAN-1:0] ext;
        ext = SEL_SPAN'(v);
        return ext[s];
    endfunction

    assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign can_accept = (state == IDLE) && len_ok;
    assign accept     = can_accept && bus.in_valid;

    assign desc    = stage_tbl[idx[ADDR_W-1:0]];
    assign op_a    = pick(pi_q, desc.sel_a);
    assign op_b    = pick(pi_q, desc.sel_b);
    assign op_c    = desc.use_prev ? acc : pick(pi_q, desc.sel_c);
    assign sel_bad = (desc.sel_a >= SEL_LIMIT) || (desc.sel_b >= SEL_LIMIT) ||
                     (desc.sel_c >= SEL_LIMIT);

    maj3_unit u_maj3 (
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .inv_a (desc.inv_a),
        .inv_b (desc.inv_b),
        .inv_c (desc.inv_c),
        .y     (stage_res)
    );

    // in_ready is forced low while reset is held, then tracks IDLE and a legal cfg_len.
    assign bus.in_ready  = rst_n && can_accept;
    assign bus.out_valid = out_valid_q;
    assign bus.out_po    = acc;
    assign busy          = busy_q;
    assign err           = err_q;

    // Stage table: written only in IDLE, so an accept on the same edge sees the new entry.
    always_ff @(posedge clk) begin
        if (cfg_we && (state == IDLE) && (cfg_addr < LEN_MAX))
            stage_tbl[cfg_addr[ADDR_W-1:0]] <= cfg_data;
    end

    // Vector and chain length captured at accept; later cfg_len changes do not affect it.
    always_ff @(posedge clk) begin
        if (accept) begin
            pi_q  <= bus.in_pi;
            len_q <= cfg_len;
        end
    end

    // Control FSM: IDLE accepts, EVAL runs one stage per cycle, DONE holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (cfg_we && (state != IDLE))
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx    <= '0;
                        acc    <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    acc <= stage_res;
                    idx <= idx + IDX_W'(1);
                    if (sel_bad)
                        err_q <= 1'b1;
                    if (idx == len_q - IDX_W'(1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAJ_SEQ_TRACE_EN
    // Per-stage result record, cleared at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_trace <= '0;
        else if (accept)
            out_trace <= '0;
        else if (state == EVAL)
            out_trace[idx[ADDR_W-1:0]] <= stage_res;
    end
`endif

endmodule

// File: tb/tb_maj_chain_sequencer.sv
// Directed bench for maj_chain_sequencer (optionally built with MAJ_SEQ_TRACE_EN).
module tb_maj_chain_sequencer;
    import maj_seq_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    stage_desc_t      cfg_data;
    logic [IDX_W-1:0] cfg_len;
    logic             busy;
    logic             err;
`ifdef MAJ_SEQ_TRACE_EN
    logic [MAX_STAGES-1:0] out_trace;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    maj_chain_sequencer_if bus ();

    maj_chain_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_len  (cfg_len),
        .bus      (bus),
        .busy     (busy),
        .err      (err)
`ifdef MAJ_SEQ_TRACE_EN
        ,
        .out_trace(out_trace)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic stage_desc_t mk(input int sa, input int sb, input int sc,
                                       input bit ia, input bit ib, input bit ic, input bit up);
        stage_desc_t d;
        d.sel_a    = SEL_W'(sa);
        d.sel_b    = SEL_W'(sb);
        d.sel_c    = SEL_W'(sc);
        d.inv_a    = ia;
        d.inv_b    = ib;
        d.inv_c    = ic;
        d.use_prev = up;
        return d;
    endfunction

    task automatic cfg_write(input int addr, input stage_desc_t d);
        cfg_addr = IDX_W'(addr);
        cfg_data = d;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Accept one vector, measure latency, check result, optionally stall the consumer.
    task automatic run_vec(input logic [NUM_PI-1:0] pi, input logic exp_po, input int exp_lat,
                           input string tag, input bit stall);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " in_ready_before"}, bus.in_ready, 1);
        bus.in_pi     = pi;
        bus.in_valid  = 1'b1;
        bus.out_ready = !stall;
        tick();
        bus.in_valid  = 1'b0;
        cfg_we        = 1'b0;
        chk({tag, " busy_after_accept"}, busy, 1);
        chk({tag, " in_ready_in_eval"}, bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " out_po"}, bus.out_po, exp_po);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                chk({tag, " stall_out_valid"}, bus.out_valid, 1);
                chk({tag, " stall_out_po"}, bus.out_po, exp_po);
                chk({tag, " stall_in_ready"}, bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
        end
        tick();
        chk({tag, " out_valid_after_hs"}, bus.out_valid, 0);
        chk({tag, " in_ready_after_hs"}, bus.in_ready, 1);
        chk({tag, " busy_after_hs"}, busy, 0);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        cfg_len       = IDX_W'(6);
        bus.in_valid  = 1'b0;
        bus.in_pi     = '0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_po", bus.out_po, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", bus.in_ready, 1);

        cfg_write(0, mk(0, 1, 2, 0, 0, 0, 0));
        cfg_write(1, mk(3, 4, 0, 0, 0, 0, 1));
        cfg_write(2, mk(5, 6, 0, 0, 0, 0, 1));
        cfg_write(3, mk(7, 8, 0, 1, 0, 1, 1));
        cfg_write(4, mk(9, 10, 0, 1, 0, 0, 1));
        cfg_write(5, mk(11, 12, 0, 0, 0, 0, 1));

        // All zeros: stages 0..5 give 0,0,0,1,1,0.
        run_vec(13'h0000, 1'b0, 6, "zeros", 1'b0);
`ifdef MAJ_SEQ_TRACE_EN
        chk("zeros trace", out_trace[5:0], 6'b011000);
`endif
        // All ones: stages 0..5 give 1,1,1,0,0,1.
        run_vec(13'h1FFF, 1'b1, 6, "ones", 1'b0);
`ifdef MAJ_SEQ_TRACE_EN
        chk("ones trace", out_trace[5:0], 6'b100111);
`endif
        // Only pi11: stages 0..5 give 0,0,0,1,1,1; consumer stalls 5 cycles.
        run_vec(13'h0800, 1'b1, 6, "pi11_stall", 1'b1);

        // Table write attempted during EVAL is dropped and flagged.
        chk("err before busy write", err, 0);
        bus.in_pi    = 13'h0000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        cfg_addr = IDX_W'(5);
        cfg_data = mk(0, 0, 0, 1, 1, 0, 0);
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("busy_write out_valid", bus.out_valid, 1);
        chk("busy_write out_po", bus.out_po, 0);
        chk("busy_write err", err, 1);
        tick();
        run_vec(13'h0000, 1'b0, 6, "rerun_zeros", 1'b0);

        // Illegal lengths keep in_ready low.
        cfg_len      = '0;
        bus.in_valid = 1'b1;
        tick();
        chk("len0 in_ready", bus.in_ready, 0);
        tick();
        chk("len0 busy", busy, 0);
        cfg_len = IDX_W'(9);
        #1;
        chk("len9 in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        cfg_len      = IDX_W'(6);

        // Reset in the middle of evaluation (acc is 1 after stages 0..2 for all-ones).
        tick();
        bus.in_pi    = 13'h1FFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst out_po", bus.out_po, 0);
        chk("midrst in_ready", bus.in_ready, 0);
        chk("midrst err", err, 0);
        tick();
        rst_n = 1'b1;
        run_vec(13'h1FFF, 1'b1, 6, "after_rst", 1'b0);
        chk("err clear before sel", err, 0);

        // Out-of-range sel_a reads 0; write and accept share one edge.
        cfg_len  = IDX_W'(1);
        cfg_addr = '0;
        cfg_data = mk(13, 1, 2, 0, 0, 0, 0);
        cfg_we   = 1'b1;
        run_vec(13'h0006, 1'b1, 1, "sel_oob", 1'b0);
        chk("sel_oob err", err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
